// File: rtl/step_ex_tsx_if.sv
// Bus bundle for the test-and-set-flag execute step.
// Handshake: ena_ is an active-low start strobe sampled on the rising clock edge.
// rdy_ and fl_we_ are driven low together for the single write cycle and float (Z) otherwise.
// fl_din floats unless the step is in its evaluate or write cycle.
interface step_ex_tsx_if #(
  parameter int WIDTH = 8,
  parameter int FLAGW = 8,
  parameter int SELW  = 3,
  parameter int FIDXW = 3
);
  logic             ena_;
  logic [2:0]       mode;
  logic [SELW-1:0]  bitsel;
  logic [FIDXW-1:0] fidx;
  logic             inv;
  logic [1:0]       comb;
  logic [WIDTH-1:0] r0_dout;
  logic [FLAGW-1:0] fl_dout;
  wire              rdy_;
  wire  [FLAGW-1:0] fl_din;
  wire              fl_we_;

  modport master (
    output ena_, mode, bitsel, fidx, inv, comb, r0_dout, fl_dout,
    input  rdy_, fl_din, fl_we_
  );

  modport slave (
    input  ena_, mode, bitsel, fidx, inv, comb, r0_dout, fl_dout,
    output rdy_, fl_din, fl_we_
  );
endinterface

// File: rtl/step_ex_tsx.sv
// Test-and-set-flag execute step.
// An ena_ strobe captures the operand and controls, one predicate is evaluated on the
// captured operand, and the result is merged into one bit of the live flag register.
// The merged flag word is driven for two cycles (evaluate, write); the second cycle also
// pulses fl_we_ and rdy_ low. All bus outputs are tri-stated when idle.
module step_ex_tsx #(
  parameter int WIDTH = 8,
  parameter int FLAGW = 8,
  parameter int SELW  = 3,
  parameter int FIDXW = 3
) (
  input  logic        clk,
  input  logic        rst_,
  step_ex_tsx_if.slave bus,
  output logic [1:0]  dbg_state,
  output logic        dbg_drv_din,
  output logic        dbg_drv_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state;
  logic             drv_din;
  logic             drv_we;
  logic [WIDTH-1:0] cap_x;
  logic [2:0]       cap_mode;
  logic [SELW-1:0]  cap_bitsel;
  logic [FIDXW-1:0] cap_fidx;
  logic             cap_inv;
  logic [1:0]       cap_comb;

  logic             pred;
  logic             res;
  logic             old_bit;
  logic             new_bit;
  logic [FLAGW-1:0] merged;

  // Sequencer: a strobe restarts from any state; drive enables are registered with the state.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      drv_din    <= 1'b0;
      drv_we     <= 1'b0;
      cap_x      <= '0;
      cap_mode   <= '0;
      cap_bitsel <= '0;
      cap_fidx   <= '0;
      cap_inv    <= 1'b0;
      cap_comb   <= '0;
    end else if (!bus.ena_) begin
      state      <= EVAL;
      drv_din    <= 1'b1;
      drv_we     <= 1'b0;
      cap_x      <= bus.r0_dout;
      cap_mode   <= bus.mode;
      cap_bitsel <= bus.bitsel;
      cap_fidx   <= bus.fidx;
      cap_inv    <= bus.inv;
      cap_comb   <= bus.comb;
    end else begin
      case (state)
        EVAL: begin
          state   <= WRITE;
          drv_din <= 1'b1;
          drv_we  <= 1'b1;
        end
        WRITE: begin
          state   <= IDLE;
          drv_din <= 1'b0;
          drv_we  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          drv_din <= 1'b0;
          drv_we  <= 1'b0;
        end
      endcase
    end
  end

  // Predicate on the captured operand; an out-of-range bit select reads as 0.
  always_comb begin
    pred = 1'b0;
    case (cap_mode)
      3'b000: pred = cap_x[0];
      3'b001: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cap_bitsel == SELW'(i)) pred = cap_x[i];
        end
      end
      3'b010: pred = (cap_x != '0);
      3'b011: pred = cap_x[WIDTH-1];
      3'b100: pred = ^cap_x;
      3'b101: pred = ~^cap_x;
      3'b110: pred = &cap_x;
      default: pred = (cap_x == '0);
    endcase
  end

  // Merge into the live flag word; an out-of-range index leaves every bit unchanged.
  always_comb begin
    res     = pred ^ cap_inv;
    old_bit = 1'b0;
    for (int i = 0; i < FLAGW; i++) begin
      if (cap_fidx == FIDXW'(i)) old_bit = bus.fl_dout[i];
    end
    case (cap_comb)
      2'b00:   new_bit = res;
      2'b01:   new_bit = old_bit & res;
      2'b10:   new_bit = old_bit | res;
      default: new_bit = old_bit ^ res;
    endcase
    merged = bus.fl_dout;
    for (int i = 0; i < FLAGW; i++) begin
      if (cap_fidx == FIDXW'(i)) merged[i] = new_bit;
    end
  end

  assign bus.fl_din = drv_din ? merged : {FLAGW{1'bz}};
  assign bus.fl_we_ = drv_we ? 1'b0 : 1'bz;
  assign bus.rdy_   = drv_we ? 1'b0 : 1'bz;

  assign dbg_state   = state;
  assign dbg_drv_din = drv_din;
  assign dbg_drv_we  = drv_we;

endmodule

// File: tb/tb_step_ex_tsx.sv
// Directed bench for step_ex_tsx: one 8/8 instance and one 6-bit-operand, 4-flag instance.
module tb_step_ex_tsx;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic clk;
  logic rst_;
  int   n_pass;
  int   n_total;

  logic [1:0] d0_state;
  logic       d0_dd;
  logic       d0_dw;
  logic [1:0] d1_state;
  logic       d1_dd;
  logic       d1_dw;

  step_ex_tsx_if #(.WIDTH(8), .FLAGW(8), .SELW(3), .FIDXW(3)) b0 ();
  step_ex_tsx_if #(.WIDTH(6), .FLAGW(4), .SELW(3), .FIDXW(3)) b1 ();

  step_ex_tsx #(.WIDTH(8), .FLAGW(8), .SELW(3), .FIDXW(3)) u0 (
    .clk(clk), .rst_(rst_), .bus(b0.slave),
    .dbg_state(d0_state), .dbg_drv_din(d0_dd), .dbg_drv_we(d0_dw)
  );

  step_ex_tsx #(.WIDTH(6), .FLAGW(4), .SELW(3), .FIDXW(3)) u1 (
    .clk(clk), .rst_(rst_), .bus(b1.slave),
    .dbg_state(d1_state), .dbg_drv_din(d1_dd), .dbg_drv_we(d1_dw)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Phase check on instance 0: state, drive enables, data when driven, strobes in WRITE.
  task automatic p0(input string tag, input logic [1:0] est, input logic [7:0] edin);
    chk({tag, ".state"}, 32'(d0_state), 32'(est));
    chk({tag, ".drv_din"}, 32'(d0_dd), 32'(est != S_IDLE));
    chk({tag, ".drv_we"}, 32'(d0_dw), 32'(est == S_WRITE));
    if (est != S_IDLE) chk({tag, ".fl_din"}, 32'(b0.fl_din), 32'(edin));
    if (est == S_WRITE) begin
      chk({tag, ".fl_we_"}, 32'(b0.fl_we_), 32'd0);
      chk({tag, ".rdy_"}, 32'(b0.rdy_), 32'd0);
    end
  endtask

  task automatic p1(input string tag, input logic [1:0] est, input logic [3:0] edin);
    chk({tag, ".state"}, 32'(d1_state), 32'(est));
    chk({tag, ".drv_din"}, 32'(d1_dd), 32'(est != S_IDLE));
    chk({tag, ".drv_we"}, 32'(d1_dw), 32'(est == S_WRITE));
    if (est != S_IDLE) chk({tag, ".fl_din"}, 32'(b1.fl_din), 32'(edin));
    if (est == S_WRITE) begin
      chk({tag, ".fl_we_"}, 32'(b1.fl_we_), 32'd0);
      chk({tag, ".rdy_"}, 32'(b1.rdy_), 32'd0);
    end
  endtask

  // driver tasks: set controls, then strobe for one edge
  task automatic set0(input logic [2:0] m, input logic [2:0] bs, input logic [7:0] x,
                      input logic [2:0] fi, input logic iv, input logic [1:0] cb,
                      input logic [7:0] fl);
    b0.mode = m; b0.bitsel = bs; b0.r0_dout = x; b0.fidx = fi;
    b0.inv = iv; b0.comb = cb; b0.fl_dout = fl;
  endtask

  task automatic set1(input logic [2:0] m, input logic [2:0] bs, input logic [5:0] x,
                      input logic [2:0] fi, input logic iv, input logic [1:0] cb,
                      input logic [3:0] fl);
    b1.mode = m; b1.bitsel = bs; b1.r0_dout = x; b1.fidx = fi;
    b1.inv = iv; b1.comb = cb; b1.fl_dout = fl;
  endtask

  task automatic strobe0();
    b0.ena_ = 1'b0;
    @(posedge clk); #1;
    b0.ena_ = 1'b1;
  endtask

  task automatic strobe1();
    b1.ena_ = 1'b0;
    @(posedge clk); #1;
    b1.ena_ = 1'b1;
  endtask

  // Full operation on instance 0 with a constant fl_dout.
  task automatic op0(input string tag, input logic [7:0] exp_din);
    strobe0();
    @(negedge clk); p0({tag, ".eval"}, S_EVAL, exp_din);
    @(negedge clk); p0({tag, ".write"}, S_WRITE, exp_din);
    @(negedge clk); p0({tag, ".idle"}, S_IDLE, 8'h00);
  endtask

  task automatic op1(input string tag, input logic [3:0] exp_din);
    strobe1();
    @(negedge clk); p1({tag, ".eval"}, S_EVAL, exp_din);
    @(negedge clk); p1({tag, ".write"}, S_WRITE, exp_din);
    @(negedge clk); p1({tag, ".idle"}, S_IDLE, 4'h0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_    = 1'b0;
    b0.ena_ = 1'b0;
    b1.ena_ = 1'b0;
    set0(3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 2'b00, 8'h00);
    set1(3'd0, 3'd0, 6'h00, 3'd0, 1'b0, 2'b00, 4'h0);

    // Reset held with the strobe low: nothing driven.
    repeat (2) @(negedge clk);
    p0("rst", S_IDLE, 8'h00);
    p1("rst1", S_IDLE, 4'h0);
    @(posedge clk); #1;
    rst_    = 1'b1;
    b0.ena_ = 1'b1;
    b1.ena_ = 1'b1;
    @(negedge clk); p0("post_rst", S_IDLE, 8'h00);

    // x!=0 on zero operand, clear bit 0 of A5.
    set0(3'b010, 3'd0, 8'h00, 3'd0, 1'b0, 2'b00, 8'hA5);
    op0("nz", 8'hA4);

    // Bit 6 of 0x40 inverted -> clear bit 3; operand changed after capture is ignored.
    set0(3'b001, 3'd6, 8'h40, 3'd3, 1'b1, 2'b00, 8'hFF);
    strobe0();
    b0.r0_dout = 8'h00;
    b0.bitsel  = 3'd0;
    @(negedge clk); p0("bit.eval", S_EVAL, 8'hF7);
    @(negedge clk); p0("bit.write", S_WRITE, 8'hF7);
    @(negedge clk); p0("bit.idle", S_IDLE, 8'h00);

    // Accumulate into bit 7.
    set0(3'b100, 3'd0, 8'h07, 3'd7, 1'b0, 2'b01, 8'h80);
    op0("acc_and", 8'h80);
    set0(3'b111, 3'd0, 8'h01, 3'd7, 1'b0, 2'b10, 8'h80);
    op0("acc_or", 8'h80);
    set0(3'b011, 3'd0, 8'h80, 3'd7, 1'b0, 2'b11, 8'h80);
    op0("acc_xor", 8'h00);

    // Remaining predicates.
    set0(3'b110, 3'd0, 8'hFF, 3'd1, 1'b0, 2'b00, 8'h00);
    op0("all1", 8'h02);
    set0(3'b110, 3'd0, 8'hFE, 3'd1, 1'b0, 2'b00, 8'hFF);
    op0("all1_no", 8'hFD);

    // Even parity, with fl_dout changed between the two driven cycles.
    set0(3'b101, 3'd0, 8'h03, 3'd2, 1'b0, 2'b00, 8'h00);
    strobe0();
    @(negedge clk); p0("live.eval", S_EVAL, 8'h04);
    b0.fl_dout = 8'hF0;
    @(negedge clk); p0("live.write", S_WRITE, 8'hF4);
    @(negedge clk); p0("live.idle", S_IDLE, 8'h00);

    // Restart during WRITE: first write completes, second op captured at the later edge.
    set0(3'b010, 3'd0, 8'h01, 3'd0, 1'b0, 2'b00, 8'h00);
    strobe0();
    @(negedge clk); p0("rs.eval1", S_EVAL, 8'h01);
    @(posedge clk); #1;
    b0.r0_dout = 8'h00;
    b0.fidx    = 3'd1;
    b0.ena_    = 1'b0;
    @(negedge clk); p0("rs.write1", S_WRITE, 8'h01);
    @(posedge clk); #1;
    b0.ena_    = 1'b1;
    b0.r0_dout = 8'h01;
    @(negedge clk); p0("rs.eval2", S_EVAL, 8'h00);
    @(negedge clk); p0("rs.write2", S_WRITE, 8'h00);
    @(negedge clk); p0("rs.idle", S_IDLE, 8'h00);

    // Strobe held low: parked in EVAL without a write.
    set0(3'b000, 3'd0, 8'h01, 3'd5, 1'b0, 2'b00, 8'h00);
    b0.ena_ = 1'b0;
    @(negedge clk); p0("hold.0", S_EVAL, 8'h20);
    @(negedge clk); p0("hold.1", S_EVAL, 8'h20);
    @(negedge clk); p0("hold.2", S_EVAL, 8'h20);
    b0.ena_ = 1'b1;
    @(negedge clk); p0("hold.write", S_WRITE, 8'h20);
    @(negedge clk); p0("hold.idle", S_IDLE, 8'h00);

    // Async reset in EVAL: outputs released at once, no write afterwards.
    set0(3'b000, 3'd0, 8'hFE, 3'd4, 1'b0, 2'b00, 8'hFF);
    strobe0();
    @(negedge clk); p0("ar.eval", S_EVAL, 8'hEF);
    #2 rst_ = 1'b0;
    #1 p0("ar.now", S_IDLE, 8'h00);
    #1 rst_ = 1'b1;
    @(negedge clk); p0("ar.after1", S_IDLE, 8'h00);
    @(negedge clk); p0("ar.after2", S_IDLE, 8'h00);

    // Narrow instance: out-of-range bitsel, out-of-range fidx, msb test.
    set1(3'b001, 3'd7, 6'h3F, 3'd2, 1'b0, 2'b00, 4'hF);
    op1("n_bitsel", 4'hB);
    set1(3'b010, 3'd0, 6'h01, 3'd7, 1'b1, 2'b00, 4'h5);
    op1("n_fidx", 4'h5);
    set1(3'b011, 3'd0, 6'h20, 3'd0, 1'b0, 2'b00, 4'h0);
    op1("n_msb", 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
